muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit next to the single-cycle ALU in the datapath.
- Executes MULT, MULTU, DIV and DIVU, which the combinational ALU cannot do. Writes a 64-bit result into the HI/LO registers.
- The control unit starts an operation with a start/busy/done handshake and stalls the pipeline while busy is high.
- Operands come from the same register-file read ports that feed the ALU in1/in2.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- in1  input  WIDTH  multiplicand / dividend (rs)
- in2  input  WIDTH  multiplier / divisor (rt)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle
- hi  output  WIDTH  MULT*: upper product half; DIV*: remainder
- lo  output  WIDTH  MULT*: lower product half; DIV*: quotient
- div_by_zero  output  1  set with done when a DIV/DIVU had in2 == 0; cleared on the next accepted start

Behaviour:
- Reset: state goes to IDLE; busy, done, div_by_zero = 0; hi = lo = 0; iteration counter = 0. Takes effect immediately, including mid-operation. The aborted result is discarded and no done pulse is issued.
- State machine:
  - IDLE: start=1 -> latch op, in1, in2; go to CALC; counter = 0.
  - CALC: one iteration per cycle; after WIDTH iterations go to FIX.
  - FIX: sign correction (one cycle); go to DONE.
  - DONE: done=1 for one cycle; hi/lo get the final result on entry. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Timing: start is sampled at the end of cycle 0.
  - busy=1 in cycles 1..WIDTH+1.
  - done=1 and busy=0 in cycle WIDTH+2.
  - Fixed latency for every op, including divide-by-zero.
- start while busy is ignored; operands and op are not re-latched. Operand changes after acceptance do not affect the result.
- hi/lo hold the last completed result until the next done. They do not change during CALC/FIX.
- Multiply: shift-add on operand magnitudes, 2*WIDTH-bit accumulator.
  - Signed: magnitudes are taken at latch time. FIX negates the 64-bit product if the operand signs differ.
  - Unsigned: FIX passes the product through unchanged.
- Divide: restoring division on magnitudes, one quotient bit per cycle, MSB first.
  - Signed quotient truncates toward zero. The remainder takes the sign of the dividend. Both corrections happen in FIX.
- Divide by zero (in2 == 0, DIV or DIVU): lo = all ones, hi = in1 as latched, div_by_zero = 1 with done.
- Signed overflow (DIV of most-negative / -1): lo = 0x80000000, hi = 0, div_by_zero = 0. No trap.
- Magnitude of the most-negative value is 2^(WIDTH-1), treated as unsigned; no overflow inside the datapath.
- done is never asserted together with busy.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- MULT -3 (0xFFFFFFFD) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU 100 / 0 -> done in cycle 34, div_by_zero=1, lo=0xFFFFFFFF, hi=0x00000064. The next accepted start clears div_by_zero.
- Start pulse and operand change in cycle 10 of a MULTU 6x7 -> ignored; result hi=0, lo=42. start asserted during done cycle -> second op accepted; its done arrives 34 cycles later.
- rst asserted in cycle 15 of a DIV -> busy, done, hi, lo = 0 immediately; no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit that sits beside the single-cycle ALU.
//   Handles MULT, MULTU, DIV and DIVU. An operation takes WIDTH+2 cycles
//   from the cycle start is sampled. The 2*WIDTH-bit result lands in HI/LO.
//   One CALC cycle does one shift-add multiply step or one restoring-divide
//   step on operand magnitudes. FIX then applies the sign corrections.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        request a new operation (sampled in IDLE or DONE only)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   in1          multiplicand / dividend (rs)
//   in2          multiplier / divisor (rt)
//   busy         operation in progress (CALC or FIX)
//   done         one-cycle completion pulse; hi/lo valid from this cycle
//   hi           MULT*: upper product half; DIV*: remainder
//   lo           MULT*: lower product half; DIV*: quotient
//   div_by_zero  set with done when a divide had in2 == 0
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic                   accept;
    logic                   last_iter;

    // Operation context latched at acceptance
    logic                   is_div;
    logic                   neg_q;      // product / quotient must be negated
    logic                   neg_r;      // remainder must be negated
    logic                   dz_op;      // divide with zero divisor
    logic [WIDTH-1:0]       dividend;   // raw in1, returned in hi on divide by zero
    logic [WIDTH-1:0]       opnd;       // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0]     acc;        // {upper, lower} working register

    logic signed [WIDTH-1:0] in1_s, in2_s;
    logic                    op_signed;
    logic                    neg_a, neg_b;
    logic [WIDTH-1:0]        mag_a, mag_b;
    logic [2*WIDTH-1:0]      result_fix;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // Magnitude as an unsigned value; the most-negative input maps to
    // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic                    neg);
        logic signed [WIDTH-1:0] n;
        n = -x;
        return neg ? $unsigned(n) : $unsigned(x);
    endfunction

    // Shift-add multiply step. The multiplier sits in the lower half and is
    // consumed LSB first. The partial product grows in from the top.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] rq,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, rq[2*WIDTH-1:WIDTH]} + {1'b0, (rq[0] ? m : {WIDTH{1'b0}})};
        return {sum, rq[WIDTH-1:1]};
    endfunction

    // Restoring divide step. The upper half is the partial remainder. The
    // lower half shifts the dividend out MSB first and the quotient in at
    // the LSB. A clear borrow bit means the trial subtraction succeeded.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] rq,
                                                    input logic [WIDTH-1:0]   d);
        logic [WIDTH:0] trial;
        trial = {rq[2*WIDTH-1:WIDTH], rq[WIDTH-1]} - {1'b0, d};
        if (!trial[WIDTH])
            return {trial[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
        return {rq[2*WIDTH-2:0], 1'b0};
    endfunction

    // Product sign correction: negate the full double-width magnitude.
    function automatic logic [2*WIDTH-1:0] fix_mul(input logic [2*WIDTH-1:0] p,
                                                   input logic               neg);
        logic signed [2*WIDTH-1:0] ps;
        ps = p;
        return neg ? $unsigned(-ps) : p;
    endfunction

    // Quotient/remainder sign correction. The quotient truncates toward zero
    // and the remainder follows the dividend sign. Divide by zero returns
    // {dividend, all ones}. The most-negative / -1 case needs no special
    // path: the magnitude quotient 2^(WIDTH-1) negates to itself.
    function automatic logic [2*WIDTH-1:0] fix_div(input logic [2*WIDTH-1:0] rq,
                                                   input logic               nq,
                                                   input logic               nr,
                                                   input logic               dz,
                                                   input logic [WIDTH-1:0]   dvd);
        logic signed [WIDTH-1:0] q, r;
        q = rq[WIDTH-1:0];
        r = rq[2*WIDTH-1:WIDTH];
        if (dz)
            return {dvd, {WIDTH{1'b1}}};
        return {(nr ? $unsigned(-r) : $unsigned(r)), (nq ? $unsigned(-q) : $unsigned(q))};
    endfunction

    // ------------------------------------------------------------------
    // Operand conditioning at acceptance
    // ------------------------------------------------------------------
    assign in1_s     = in1;
    assign in2_s     = in2;
    assign op_signed = ~op[0];
    assign neg_a     = op_signed && (in1_s < 0);
    assign neg_b     = op_signed && (in2_s < 0);
    assign mag_a     = magnitude(in1_s, neg_a);
    assign mag_b     = magnitude(in2_s, neg_b);

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    assign busy      = (state == CALC) || (state == FIX);
    assign done      = (state == DONE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration counter, result registers and the divide-by-zero flag.
    // hi/lo only move on the FIX -> DONE edge, so they hold the previous
    // result throughout CALC and FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept)
                cnt <= '0;
            else if (state == CALC)
                cnt <= cnt + CNT_W'(1);

            if (state == FIX) begin
                hi          <= result_fix[2*WIDTH-1:WIDTH];
                lo          <= result_fix[WIDTH-1:0];
                div_by_zero <= dz_op;
            end else if (accept) begin
                div_by_zero <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: latch on accept, iterate in CALC
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div   <= op[1];
            neg_q    <= neg_a ^ neg_b;
            neg_r    <= neg_a;
            dz_op    <= op[1] && (in2 == '0);
            dividend <= in1;
            if (op[1]) begin
                opnd <= mag_b;
                acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
                opnd <= mag_a;
                acc  <= {{WIDTH{1'b0}}, mag_b};
            end
        end else if (state == CALC) begin
            acc <= is_div ? div_step(acc, opnd) : mul_step(acc, opnd);
        end
    end

    // ------------------------------------------------------------------
    // FIX stage: sign correction feeding hi/lo
    // ------------------------------------------------------------------
    assign result_fix = is_div ? fix_div(acc, neg_q, neg_r, dz_op, dividend)
                               : fix_mul(acc, neg_q);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] in1, in2;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] prev_hi, prev_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .in1        (in1),
        .in2        (in2),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] mh, output logic [W-1:0] ml, output logic mdz);
        longint sa, sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        mdz = 1'b0;
        p   = '0;
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) begin
                    p = {a, 32'hFFFF_FFFF}; mdz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    p = {32'h0, 32'h8000_0000};
                end else begin
                    p[31:0]  = 32'(sa / sb);
                    p[63:32] = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 0) begin
                    p = {a, 32'hFFFF_FFFF}; mdz = 1'b1;
                end else begin
                    p[31:0]  = a / b;
                    p[63:32] = a % b;
                end
            end
        endcase
        mh = p[63:32];
        ml = p[31:0];
    endfunction

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
    endtask

    // Called at the negedge of the cycle in which start was presented.
    // Returns at the negedge of the done cycle.
    task automatic finish(input string tag, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input logic e_dz, input int glitch_cyc);
        int cyc;
        bit busy_ok;
        bit hold_ok;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1   = ~in1;
        in2   = in2 + 32'h1234;
        op    = op ^ 2'b01;
        cyc   = 1;
        check($sformatf("%s dz_clear", tag), {63'b0, div_by_zero}, 64'd0);
        while (!done && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
            start = (cyc == glitch_cyc);
            if (cyc == glitch_cyc) begin
                in1 = $urandom;
                in2 = $urandom;
                op  = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check($sformatf("%s latency", tag), 64'(cyc), 64'd34);
        check($sformatf("%s done_not_busy", tag), {62'b0, done, busy}, 64'd2);
        check($sformatf("%s busy_window", tag), {63'b0, busy_ok}, 64'd1);
        check($sformatf("%s hold", tag), {63'b0, hold_ok}, 64'd1);
        check($sformatf("%s hi", tag), {32'b0, hi}, {32'b0, e_hi});
        check($sformatf("%s lo", tag), {32'b0, lo}, {32'b0, e_lo});
        check($sformatf("%s dz", tag), {63'b0, div_by_zero}, {63'b0, e_dz});
        prev_hi = e_hi;
        prev_lo = e_lo;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input logic e_dz, input int glitch_cyc);
        @(negedge clk);
        check($sformatf("%s pulse_end", tag), {63'b0, done}, 64'd0);
        issue(o, a, b);
        finish(tag, e_hi, e_lo, e_dz, glitch_cyc);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs [12];

    initial begin
        logic [W-1:0] mh, ml;
        logic         mdz;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        bit           no_done;

        vecs[0]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,         1'b0};
        vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6]  = '{2'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
        vecs[9]  = '{2'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
        vecs[11] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'd0; in1 = '0; in2 = '0;
        prev_hi = '0; prev_lo = '0;
        repeat (2) @(negedge clk);
        check("reset state", {busy, done, div_by_zero, hi, lo}, 67'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", {61'b0, busy, done, div_by_zero}, 64'd0);

        // Table-driven directed vectors
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz, 0);

        // Start pulse plus operand change in cycle 10 is ignored
        run_op("glitch", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 10);

        // Back-to-back: start presented during the done cycle
        @(negedge clk);
        issue(2'd1, 32'd6, 32'd7);
        finish("b2b_first", 32'd0, 32'd42, 1'b0, 0);
        issue(2'd3, 32'd100, 32'd7);
        finish("b2b_second", 32'd2, 32'd14, 1'b0, 0);

        // Reset in cycle 15 of a DIV
        @(negedge clk);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre-reset busy", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("async reset", {busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        check("no done after abort", {63'b0, no_done}, 64'd1);
        prev_hi = '0;
        prev_lo = '0;
        run_op("post-reset", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            model(ro, ra, rb, mh, ml, mdz);
            if ($urandom_range(0, 3) == 0) begin
                issue(ro, ra, rb);
                finish($sformatf("rnd%0d", i), mh, ml, mdz, 0);
            end else begin
                run_op($sformatf("rnd%0d", i), ro, ra, rb, mh, ml, mdz,
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 33)) : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
